// File: rtl/bcd_pkg.sv
// Shared constants for the cascaded BCD up/down counter.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX        = 4'd9;
  localparam logic [3:0] BCD_MIN        = 4'd0;
  localparam int         DEFAULT_DIGITS = 3;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit (0..9) with clear, sanitising load, increment and decrement.
// Latency: q updates one cycle after the qualifying edge.
// Backpressure: none; enables are single-cycle strobes from the parent.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       at_max,
  output logic       at_min
);

  // Terminal flags let the parent build the ripple enables without adders.
  assign at_max = (q == BCD_MAX);
  assign at_min = (q == BCD_MIN);

  // Digit state: clear beats load beats step; invalid load nibbles become 0.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      q <= BCD_MIN;
    end else if (clr) begin
      q <= BCD_MIN;
    end else if (load) begin
      q <= (d > BCD_MAX) ? BCD_MIN : d;
    end else if (inc) begin
      q <= at_max ? BCD_MIN : q + 4'd1;
    end else if (dec) begin
      q <= at_min ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascaded multi-digit BCD up/down counter with wrap or saturate at terminal count.
// Latency: q and Load_err one cycle after the edge; Cout is combinational.
// Backpressure: none; Cout can drive Cin of a further stage.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Cin,
  input  logic                  Up,
  input  logic                  Clr,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Load_data,
  output logic [4*DIGITS-1:0]   q,
  output logic                  Cout,
  output logic                  Load_err
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] lower_max;
  logic [DIGITS-1:0] lower_min;
  logic [DIGITS-1:0] inc_en;
  logic [DIGITS-1:0] dec_en;
  logic              all_max;
  logic              all_min;
  logic              terminal;
  logic              step;
  logic              load_bad;

  // Prefix AND of lower-digit terminal flags: digit k moves only when all below it roll over.
  always_comb begin
    logic max_run;
    logic min_run;
    max_run   = 1'b1;
    min_run   = 1'b1;
    lower_max = '0;
    lower_min = '0;
    for (int k = 0; k < DIGITS; k++) begin
      lower_max[k] = max_run;
      lower_min[k] = min_run;
      max_run      = max_run & at_max[k];
      min_run      = min_run & at_min[k];
    end
    all_max = max_run;
    all_min = min_run;
  end

  // Saturating mode suppresses the step at the terminal count; Cout ignores WRAP.
  assign terminal = Up ? all_max : all_min;
  assign step     = Cin & (WRAP | ~terminal);
  assign inc_en   = {DIGITS{step & Up}} & lower_max;
  assign dec_en   = {DIGITS{step & ~Up}} & lower_min;
  assign Cout     = Cin & terminal;

  // Flag any load nibble above 9 so the error register can pulse.
  always_comb begin
    load_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (Load_data[4*k +: 4] > BCD_MAX) load_bad = 1'b1;
    end
  end

  // One-cycle error pulse after an invalid load; a simultaneous clear suppresses it.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Load_err <= 1'b0;
    end else begin
      Load_err <= Load & ~Clr & load_bad;
    end
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .inc    (inc_en[g]),
        .dec    (dec_en[g]),
        .clr    (Clr),
        .load   (Load),
        .d      (Load_data[4*g +: 4]),
        .q      (q[4*g +: 4]),
        .at_max (at_max[g]),
        .at_min (at_min[g])
      );
    end
  endgenerate

endmodule
